// File: rtl/axis_arb_pkg.sv
// axis_arb_pkg: shared FSM state type and default sizing for the packet arbiter
package axis_arb_pkg;
    typedef enum logic {IDLE, LOCKED} arb_state_t;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_NUM_SRC = 4;
endpackage

// File: rtl/axis_reg_slice.sv
// axis_reg_slice: single-stage forward register slice with full-throughput valid/ready
module axis_reg_slice #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);
    assign in_ready = !out_valid || out_ready;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_valid && in_ready) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: rtl/axis_pkt_arbiter.sv
// axis_pkt_arbiter: packet-locked round-robin AXIS arbiter with a registered output stage
module axis_pkt_arbiter
    import axis_arb_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_SRC    = DEF_NUM_SRC,
    parameter int ID_WIDTH   = $clog2(NUM_SRC)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_SRC-1:0]            s_axis_tvalid,
    input  logic [NUM_SRC-1:0]            s_axis_tlast,
    output logic [NUM_SRC-1:0]            s_axis_tready,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic                          m_axis_tvalid,
    output logic                          m_axis_tlast,
    output logic [ID_WIDTH-1:0]           m_axis_tid,
    input  logic                          m_axis_tready,
    output logic                          busy,
    output logic [ID_WIDTH-1:0]           grant_id,
    output logic [15:0]                   pkt_count
);
    localparam int PW = DATA_WIDTH + ID_WIDTH + 1;
    arb_state_t state, state_nx;
    logic [ID_WIDTH-1:0] last_grant, pick;
    logic [15:0] pkt_cnt;
    logic any_valid, slice_ready, sel_valid, sel_last, accept_last;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [PW-1:0] slice_out;
    assign any_valid   = |s_axis_tvalid;
    assign sel_valid   = (state == LOCKED) && s_axis_tvalid[grant_id];
    assign sel_last    = s_axis_tlast[grant_id];
    assign sel_data    = s_axis_tdata[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
    assign accept_last = sel_valid && slice_ready && sel_last;
    assign s_axis_tready = (state == LOCKED && slice_ready) ? NUM_SRC'(1) << grant_id : '0;
    assign busy      = state == LOCKED;
    assign pkt_count = pkt_cnt;
    assign {m_axis_tid, m_axis_tlast, m_axis_tdata} = slice_out;
    // Scan farthest-first so the nearest valid source after last_grant wins.
    always_comb begin
        pick = '0;
        for (int k = NUM_SRC; k >= 1; k--) begin
            if (s_axis_tvalid[(int'(last_grant) + k) % NUM_SRC])
                pick = ID_WIDTH'((int'(last_grant) + k) % NUM_SRC);
        end
    end
    always_comb begin
        state_nx = state;
        state_nx = (state == IDLE) ? (any_valid ? LOCKED : IDLE) : (accept_last ? IDLE : LOCKED);
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            grant_id   <= '0;
            last_grant <= ID_WIDTH'(NUM_SRC - 1);
            pkt_cnt    <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && any_valid) grant_id <= pick;
            if (accept_last) last_grant <= grant_id;
            if (m_axis_tvalid && m_axis_tready && m_axis_tlast) pkt_cnt <= pkt_cnt + 16'd1;
        end
    end
    axis_reg_slice #(.WIDTH(PW)) u_slice (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   ({grant_id, sel_last, sel_data}),
        .in_valid  (sel_valid),
        .in_ready  (slice_ready),
        .out_data  (slice_out),
        .out_valid (m_axis_tvalid),
        .out_ready (m_axis_tready)
    );
endmodule

// File: tb/tb_axis_pkt_arbiter.sv
// tb_axis_pkt_arbiter: directed checks of arbitration order, packet locking, stalls, reset and counter wrap
module tb_axis_pkt_arbiter;
    localparam int DW = 32;
    localparam int NS = 4;
    localparam int IW = 2;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [NS*DW-1:0] s_tdata = '0;
    logic [NS-1:0] s_tvalid = '0, s_tlast = '0, s_tready;
    logic [DW-1:0] m_tdata;
    logic m_tvalid, m_tlast, busy;
    logic m_tready = 1'b1;
    logic [IW-1:0] m_tid, grant_id;
    logic [15:0] pkt_count;
    logic [DW:0] sbuf [NS][512];
    int wp[NS], rp[NS], orp[NS];
    logic [DW-1:0] cap_dat [1024];
    logic [IW-1:0] cap_tid [1024];
    logic cap_last [1024];
    int cap_cyc [1024];
    int ncap = 0, cyc = 0, n_cmp = 0, n_err = 0;
    logic [NS-1:0] en = '0, rdy_or = '0;
    bit rand_rdy = 0, hold_pend = 0;
    logic [DW+IW:0] held;
    always #5 clk = ~clk;
    axis_pkt_arbiter dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tlast  (s_tlast),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tlast  (m_tlast),
        .m_axis_tid    (m_tid),
        .m_axis_tready (m_tready),
        .busy          (busy),
        .grant_id      (grant_id),
        .pkt_count     (pkt_count)
    );
    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask
    task automatic push(int s, logic [DW-1:0] d, logic l);
        sbuf[s][wp[s]] = {l, d};
        wp[s]++;
    endtask
    // One cycle: drive at negedge, sample before posedge, retire accepted source beats.
    task automatic step();
        logic [NS-1:0] acc;
        if (rand_rdy) m_tready = 1'($urandom_range(0, 1));
        for (int i = 0; i < NS; i++) begin
            s_tvalid[i] = en[i] && (rp[i] != wp[i]);
            s_tdata[i*DW +: DW] = s_tvalid[i] ? sbuf[i][rp[i]][DW-1:0] : '0;
            s_tlast[i] = s_tvalid[i] ? sbuf[i][rp[i]][DW] : 1'b0;
        end
        #1;
        if (hold_pend) begin
            check("stall_valid", 64'(m_tvalid), 64'd1);
            check("stall_hold", 64'({m_tid, m_tlast, m_tdata}), 64'(held));
        end
        hold_pend = rst_n && m_tvalid && !m_tready;
        held = {m_tid, m_tlast, m_tdata};
        check("tready_onehot", 64'($countones(s_tready) <= 1), 64'd1);
        rdy_or |= s_tready;
        if (rst_n && m_tvalid && m_tready && ncap < 1024) begin
            cap_dat[ncap] = m_tdata;
            cap_tid[ncap] = m_tid;
            cap_last[ncap] = m_tlast;
            cap_cyc[ncap] = cyc;
            ncap++;
        end
        acc = s_tvalid & s_tready;
        @(posedge clk);
        for (int i = 0; i < NS; i++) if (acc[i]) rp[i]++;
        cyc++;
        @(negedge clk);
    endtask
    task automatic run_until(int n, int budget, string tag);
        int b = 0;
        while (ncap < n && b < budget) begin
            step();
            b++;
        end
        check(tag, 64'(ncap), 64'(n));
    endtask
    task automatic do_reset();
        rst_n = 1'b0;
        en = '0;
        rand_rdy = 0;
        m_tready = 1'b1;
        ncap = 0;
        for (int i = 0; i < NS; i++) begin
            wp[i] = 0;
            rp[i] = 0;
            orp[i] = 0;
        end
        step();
        step();
        rst_n = 1'b1;
        hold_pend = 0;
    endtask
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        int exp_t[5];
        int total, s, n;
        exp_t = '{0, 1, 2, 3, 0};
        @(negedge clk);
        do_reset();
        check("rst_m_tvalid", 64'(m_tvalid), 0);
        check("rst_m_tlast", 64'(m_tlast), 0);
        check("rst_m_tdata", 64'(m_tdata), 0);
        check("rst_m_tid", 64'(m_tid), 0);
        check("rst_s_tready", 64'(s_tready), 0);
        check("rst_busy", 64'(busy), 0);
        check("rst_grant", 64'(grant_id), 0);
        check("rst_pkt_count", 64'(pkt_count), 0);
        // Round robin over four single-beat requesters, source 0 requesting twice.
        for (int i = 0; i < NS; i++) push(i, 32'hA0 + 32'(i), 1'b1);
        push(0, 32'hA4, 1'b1);
        en = '1;
        run_until(5, 40, "rr_done");
        for (int k = 0; k < 5; k++) begin
            check("rr_tid", 64'(cap_tid[k]), 64'(exp_t[k]));
            check("rr_data", 64'(cap_dat[k]), 64'(32'hA0 + 32'(k)));
        end
        step();
        check("rr_pkt_count", 64'(pkt_count), 5);
        check("rr_idle_busy", 64'(busy), 0);
        // Source 2 packet locks out source 1.
        do_reset();
        for (int b = 0; b < 4; b++) push(2, 32'h10 + 32'(b), b == 3);
        push(1, 32'h21, 1'b1);
        en = 4'b0100;
        step();
        en = 4'b0110;
        rdy_or = '0;
        run_until(4, 30, "lock_beats");
        check("lock_rdy1", 64'(rdy_or[1]), 0);
        run_until(5, 30, "lock_done");
        for (int k = 0; k < 4; k++) begin
            check("lock_tid", 64'(cap_tid[k]), 2);
            check("lock_data", 64'(cap_dat[k]), 64'(32'h10 + 32'(k)));
        end
        check("lock_first_last", 64'(cap_last[0]), 0);
        check("lock_end_last", 64'(cap_last[3]), 1);
        check("lock_contig", 64'(cap_cyc[3] - cap_cyc[0]), 3);
        check("lock_next_tid", 64'(cap_tid[4]), 1);
        check("lock_next_data", 64'(cap_dat[4]), 64'h21);
        // Lone requester: one arbitration cycle between its packets.
        do_reset();
        for (int b = 0; b < 6; b++) push(3, 32'h30 + 32'(b), b[0]);
        en = 4'b1000;
        run_until(6, 40, "solo_done");
        for (int k = 0; k < 6; k++) begin
            check("solo_tid", 64'(cap_tid[k]), 3);
            check("solo_data", 64'(cap_dat[k]), 64'(32'h30 + 32'(k)));
        end
        check("solo_in_pkt", 64'(cap_cyc[1] - cap_cyc[0]), 1);
        check("solo_gap1", 64'(cap_cyc[2] - cap_cyc[1]), 2);
        check("solo_gap2", 64'(cap_cyc[4] - cap_cyc[3]), 2);
        // Random backpressure, 50 packets of 1..8 beats.
        do_reset();
        total = 0;
        for (int p = 0; p < 50; p++) begin
            s = int'($urandom_range(0, NS - 1));
            n = int'($urandom_range(1, 8));
            for (int b = 0; b < n; b++) push(s, {s[7:0], 8'(p), 16'(b)}, b == n - 1);
            total += n;
        end
        en = '1;
        rand_rdy = 1;
        run_until(total, 4000, "rand_done");
        rand_rdy = 0;
        m_tready = 1'b1;
        for (int k = 0; k < ncap; k++) begin
            s = int'(cap_tid[k]);
            check("rand_beat", 64'({cap_last[k], cap_dat[k]}), 64'(sbuf[s][orp[s]]));
            check("rand_inv", 64'(~cap_dat[k]), 64'(~sbuf[s][orp[s]][DW-1:0]));
            orp[s]++;
        end
        for (int i = 0; i < NS; i++) check("rand_count", 64'(orp[i]), 64'(wp[i]));
        check("rand_pkt_count", 64'(pkt_count), 50);
        // Reset mid-packet with a held output beat.
        do_reset();
        for (int b = 0; b < 4; b++) push(1, 32'h40 + 32'(b), b == 3);
        en = 4'b0010;
        m_tready = 1'b0;
        step();
        step();
        step();
        check("mid_pre_valid", 64'(m_tvalid), 1);
        check("mid_pre_busy", 64'(busy), 1);
        rst_n = 1'b0;
        step();
        check("mid_valid", 64'(m_tvalid), 0);
        check("mid_busy", 64'(busy), 0);
        check("mid_pkt_count", 64'(pkt_count), 0);
        check("mid_s_tready", 64'(s_tready), 0);
        rst_n = 1'b1;
        rp[1] = wp[1];
        push(2, 32'h50, 1'b1);
        push(3, 32'h60, 1'b1);
        en = '1;
        m_tready = 1'b1;
        ncap = 0;
        run_until(1, 20, "mid_regrant");
        check("mid_tid", 64'(cap_tid[0]), 2);
        check("mid_data", 64'(cap_dat[0]), 64'h50);
        // Packet counter wrap, preloaded near the top.
        do_reset();
        force dut.pkt_cnt = 16'hFFFE;
        #1;
        release dut.pkt_cnt;
        check("wrap_pre", 64'(pkt_count), 64'hFFFE);
        push(0, 32'h70, 1'b1);
        push(0, 32'h71, 1'b1);
        en = 4'b0001;
        run_until(1, 20, "wrap_first");
        check("wrap_ffff", 64'(pkt_count), 64'hFFFF);
        run_until(2, 20, "wrap_second");
        check("wrap_zero", 64'(pkt_count), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
